// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end sharing one signed 32x32 multiplier pipeline of depth LAT.
// Define MUL_ARBITER_ASSERT_EN to compile in protocol assertions and a shadow product model.
module mul_arbiter #(
    parameter int LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic signed [31:0]  req0_a,
    input  logic signed [31:0]  req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic signed [31:0]  req1_a,
    input  logic signed [31:0]  req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic signed [63:0]  rsp_c
);

    logic               ptr;
    logic               stall;
    logic               grant0;
    logic               grant1;
    logic               grant;
    logic signed [31:0] a_sel;
    logic signed [31:0] b_sel;

    logic               vld_p  [LAT];
    logic               id_p   [LAT];
    logic signed [63:0] prod_p [LAT];

    function automatic logic signed [63:0] mul_full(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        ax = a;
        bx = b;
        return ax * bx;
    endfunction

    assign stall = vld_p[LAT-1] && !rsp_ready;

    // Pointer only breaks ties; a lone valid is always served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !stall) begin
            grant0 = req0_valid && (!req1_valid || !ptr);
            grant1 = req1_valid && (!req0_valid ||  ptr);
        end
    end

    assign grant      = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        a_sel = req0_a;
        b_sel = req0_b;
        if (grant1) begin
            a_sel = req1_a;
            b_sel = req1_b;
        end
    end

    // Stage 0 captures the grant; later stages shift unless stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                vld_p[i] <= 1'b0;
                id_p[i]  <= 1'b0;
            end
        end else begin
            if (grant)
                ptr <= grant0;
            if (!stall) begin
                vld_p[0] <= grant;
                id_p[0]  <= grant1;
                for (int i = 1; i < LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                    id_p[i]  <= id_p[i-1];
                end
            end
        end
    end

    // Only the output stage needs a defined value out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_p[LAT-1] <= '0;
        end else if (!stall) begin
            prod_p[0] <= mul_full(a_sel, b_sel);
            for (int i = 1; i < LAT; i++)
                prod_p[i] <= prod_p[i-1];
        end
    end

    assign rsp_valid = vld_p[LAT-1];
    assign rsp_id    = id_p[LAT-1];
    assign rsp_c     = prod_p[LAT-1];

`ifdef MUL_ARBITER_ASSERT_EN
    logic signed [63:0] shadow_p [LAT];

    always_ff @(posedge clk) begin
        if (!stall) begin
            shadow_p[0] <= $signed({{32{a_sel[31]}}, a_sel}) * $signed({{32{b_sel[31]}}, b_sel});
            for (int i = 1; i < LAT; i++)
                shadow_p[i] <= shadow_p[i-1];
        end
    end

    a_grant_mutex: assert property (@(posedge clk) !(req0_ready && req1_ready));
    a_no_grant_in_stall: assert property (@(posedge clk) stall |-> !(req0_ready || req1_ready));
    a_stable_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
        stall |=> ($stable(rsp_valid) && $stable(rsp_id) && $stable(rsp_c)));
    a_product: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (rsp_c == shadow_p[LAT-1]));
`endif

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, multiplier pipeline depth in cycles (legal 1..4).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1, requester N has an operand pair pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1, requester N granted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32, signed operands.
REQ-007 SHALL have port rsp_valid, output, 1, result available.
REQ-008 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-009 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-010 SHALL have port rsp_c, output, 64, signed product.

Function
REQ-011 SHALL share one signed 32x32 multiplier between two requesters; transfer on reqN_valid && reqN_ready.
REQ-012 SHALL compute rsp_c as the full-precision two's-complement product of the granted A and B, sign-extended to 64 bits, with no truncation or overflow.
REQ-013 SHALL arbitrate round-robin with a 1-bit priority pointer: on a single valid, grant it; on both valid, grant the pointer's side.
REQ-014 SHALL set the pointer to the non-granted index after every grant and hold it in cycles with no grant.
REQ-015 SHALL assert at most one reqN_ready per cycle; reqN_ready may depend combinationally on req valids, the pointer and stall.
REQ-016 SHALL define stall = rsp_valid && !rsp_ready and SHALL assert no reqN_ready while stall is high.
REQ-017 SHALL carry valid, id and partial/final product through LAT register stages; rsp_* SHALL be driven from the last stage.
REQ-018 SHALL present a result LAT cycles after its grant when no stall occurs: a grant at edge T gives rsp_valid at edge T+LAT.
REQ-019 SHALL freeze every stage while stall is high, holding rsp_valid, rsp_id and rsp_c stable until accepted.
REQ-020 SHALL accept a new grant in the same cycle a result is accepted, sustaining one result per cycle at full throughput.
REQ-021 SHALL return results in grant order; no reordering, drops or duplication.
REQ-022 SHALL, when neither valid is high in a non-stalled cycle, insert a bubble (valid=0) into stage 1.

Reset
REQ-023 SHALL, on a clk edge with rst_n=0, clear all stage valids, the pointer (=0), rsp_valid (=0), rsp_id (=0) and rsp_c (=0).
REQ-024 SHALL discard in-flight operations on reset mid-operation with no result emitted for them.
REQ-025 SHALL hold req0_ready and req1_ready at 0 while rst_n=0.

Configuration
REQ-026 SHALL, when MUL_ARBITER_ASSERT_EN is defined, compile in concurrent assertions that check: grants are mutually exclusive; no grant during stall; rsp_* stable under stall; rsp_c equals the product of the operands granted LAT unstalled cycles earlier, tracked by a shadow model.
REQ-027 SHALL, when MUL_ARBITER_ASSERT_EN is undefined, contain no assertion or shadow logic, with identical ports and cycle behaviour.

Verification
REQ-028 Single product: req0 A=7, B=-3, LAT=2, rsp_ready=1 -> rsp_valid 2 cycles after the grant, rsp_c=-21, rsp_id=0.
REQ-029 Extremes: A=32'h80000000, B=32'h80000000 -> rsp_c=64'h4000000000000000; A=-1, B=1 -> rsp_c=64'hFFFFFFFFFFFFFFFF.
REQ-030 Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-031 Backpressure: rsp_ready=0 for 3 cycles while rsp_valid=1 -> rsp_c/rsp_id constant, both ready=0; results resume in order after release.
REQ-032 Reset mid-flight: rst_n low 1 cycle with 2 ops in the pipe -> rsp_valid=0 next cycle, pointer=0, no stale result appears.
REQ-033 Throughput: req1 valid continuously, rsp_ready=1, operands i*i for i=1..8 -> 8 consecutive rsp_valid cycles with rsp_c=1,4,...,64.
